bin2bcd_seq: RTL and testbench

- Sequential shift-add-3 ("double dabble") converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the 7-segment decoder stage; each 4-bit digit slice of bcd_out drives one decoder's seg_data input.
- Lets counters, timers and sensor values show as decimal on the on-board displays.
- One bit is processed per clock. Handshake is start/busy/done.

---
 rtl/bin2bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin2bcd_seq : one-bit-per-clock double-dabble binary to packed BCD       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   scratch_step;
  logic [DIGITS-1:0]  ge5;
  logic [31:0]        bin_ext;

  assign bin_ext = 32'(bin_in);

  // Add-3 then shift, fused per digit: a digit >= 5 always carries a 1 into
  // the next digit after adjustment, and its low three bits become d+3 mod 8.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] d;
    logic [2:0] lo3;
    logic       in_bit;

    assign d      = scratch_q[4*k +: 4];
    assign ge5[k] = (d >= 4'd5);
    assign lo3    = ge5[k] ? (d[2:0] + 3'd3) : d[2:0];

    if (k == 0) begin : g_lsd
      assign in_bit = shift_q[BIN_W-1];
    end else begin : g_upper
      assign in_bit = ge5[k-1];
    end

    assign scratch_step[4*k +: 4] = {lo3, in_bit};
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d    = bin_in;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = (bin_ext > MAX_VAL);
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        shift_d   = shift_q << 1;
        scratch_d = scratch_step;
        cnt_d     = cnt_q - CNT_W'(1);
        // Outputs only change here, so downstream never sees partial digits.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d      = scratch_step;
          overflow_d = ovf_pend_q;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == S_CONV);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bin2bcd_seq : self-checking bench, 3-digit and 2-digit instances      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bin2bcd_seq;

  localparam int BIN_W = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy, done, overflow;
  logic [11:0] bcd_out;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd_out2;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int ncyc = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ncyc <= ncyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    if ((done && busy) || (done2 && busy2)) overlap_cnt <= overlap_cnt + 1;
  end

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Decimal digits straight from arithmetic: value mod 10^nd, split by /10.
  function automatic logic [19:0] model_bcd(input int v, input int nd);
    int p = 1;
    int m;
    logic [19:0] r = '0;
    for (int i = 0; i < nd; i++) p = p * 10;
    m = v % p;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v, input int nd);
    int p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return (v > p - 1);
  endfunction

  task automatic run_conv(input logic [7:0] v, output int edges, output int busy_cycles,
                          output bit timeout);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    edges = 0; busy_cycles = 0; timeout = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!done) begin
      if (busy) busy_cycles++;
      if (edges >= 40) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic wait_done(output bit timeout);
    int n = 0;
    timeout = 1'b0;
    while (!done) begin
      if (n >= 40) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic verify(input string nm, input int edges, input int bc, input bit to,
                        input logic [11:0] eb, input logic eo, input logic [7:0] eb2,
                        input logic eo2);
    chk({nm, "_timeout"}, 32'(to), 32'd0);
    chk({nm, "_latency"}, 32'(edges), 32'(BIN_W));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(BIN_W));
    chk({nm, "_bcd3"}, 32'(bcd_out), 32'(eb));
    chk({nm, "_ovf3"}, 32'(overflow), 32'(eo));
    chk({nm, "_done2"}, 32'(done2), 32'd1);
    chk({nm, "_bcd2"}, 32'(bcd_out2), 32'(eb2));
    chk({nm, "_ovf2"}, 32'(overflow2), 32'(eo2));
  endtask

  initial begin
    vec_t tbl[8];
    int   edges, bc, dc, d1, d2;
    bit   to;
    logic [7:0] v;

    tbl[0] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1};
    tbl[2] = '{8'd9,   12'h009, 1'b0, 8'h09, 1'b0};
    tbl[3] = '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'd231, 12'h231, 1'b0, 8'h31, 1'b1};
    tbl[5] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0};
    tbl[6] = '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0};
    tbl[7] = '{8'd1,   12'h001, 1'b0, 8'h01, 1'b0};

    rst = 1'b1; start = 1'b0; bin_in = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bcd", 32'(bcd_out), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_bcd2", 32'(bcd_out2), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_conv(tbl[i].bin, edges, bc, to);
      verify($sformatf("tbl%0d", i), edges, bc, to, tbl[i].bcd3, tbl[i].ovf3,
             tbl[i].bcd2, tbl[i].ovf2);
    end

    // Back-to-back: start held high through done; second value swapped in while busy.
    @(negedge clk);
    start = 1'b1; bin_in = 8'd42;
    @(posedge clk);
    dc = done_cnt;
    @(negedge clk);
    bin_in = 8'd199;
    wait_done(to);
    chk("b2b_first_timeout", 32'(to), 32'd0);
    d1 = ncyc;
    chk("b2b_first_bcd", 32'(bcd_out), 32'h042);
    @(negedge clk);
    start = 1'b0;
    wait_done(to);
    chk("b2b_second_timeout", 32'(to), 32'd0);
    d2 = ncyc;
    chk("b2b_second_bcd", 32'(bcd_out), 32'h199);
    chk("b2b_second_bcd2", 32'(bcd_out2), 32'h99);
    chk("b2b_second_ovf2", 32'(overflow2), 32'd1);
    chk("b2b_spacing", 32'(d2 - d1), 32'(BIN_W + 1));
    repeat (15) @(negedge clk);
    chk("b2b_done_count", 32'(done_cnt - dc), 32'd2);

    // start and bin_in churn while busy must be ignored.
    @(negedge clk);
    start = 1'b1; bin_in = 8'd77;
    @(posedge clk);
    dc = done_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      bin_in = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(to);
    chk("ignore_timeout", 32'(to), 32'd0);
    chk("ignore_bcd", 32'(bcd_out), 32'h077);
    repeat (12) @(negedge clk);
    chk("ignore_done_count", 32'(done_cnt - dc), 32'd1);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    start = 1'b1; bin_in = 8'd123;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dc = done_cnt;
    repeat (3) @(posedge clk);
    #2;
    chk("midreset_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_bcd", 32'(bcd_out), 32'd0);
    chk("midreset_ovf", 32'(overflow), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt - dc), 32'd0);
    run_conv(8'd50, edges, bc, to);
    verify("after_reset", edges, bc, to, 12'h050, 1'b0, 8'h50, 1'b0);

    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom_range(0, 255));
      run_conv(v, edges, bc, to);
      verify($sformatf("rand%0d_v%0d", i, v), edges, bc, to,
             model_bcd(int'(v), 3) & 20'hfff, model_ovf(int'(v), 3),
             8'(model_bcd(int'(v), 2)), model_ovf(int'(v), 2));
    end

    repeat (3) @(negedge clk);
    chk("done_busy_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
